// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG target-side TAP responder.
package jtag_pkg;

  // TAP controller states, in the standard 1149.1 listing order.
  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  // All-ones BYPASS opcode; users slice the low IR_WIDTH bits.
  localparam logic [31:0] BYPASS = 32'hFFFF_FFFF;

  // Fixed pattern loaded into the low bits of the IR shifter in Capture-IR.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // Standard TAP transition on a tck rise for the given tms value.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR   : SHIFT_DR;
      SHIFT_DR: n = tms ? EX1_DR   : SHIFT_DR;
      EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR   : SHIFT_IR;
      SHIFT_IR: n = tms ? EX1_IR   : SHIFT_IR;
      EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Synchronizes the asynchronous JTAG pins into the clk domain and turns the
// synced tck into single-clk rise/fall pulses.
module jtag_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tms_o,
  output logic tdi_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  logic [SYNC_STAGES-1:0] tck_q;
  logic [SYNC_STAGES-1:0] tms_q;
  logic [SYNC_STAGES-1:0] tdi_q;
  logic                   tck_prev_q;

  // Synchronizer chains plus the delayed tck copy; all cleared together so
  // stale contents never fake an edge after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_q[0] <= tck_i;
      tms_q[0] <= tms_i;
      tdi_q[0] <= tdi_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tck_q[i] <= tck_q[i-1];
        tms_q[i] <= tms_q[i-1];
        tdi_q[i] <= tdi_q[i-1];
      end
      tck_prev_q <= tck_q[SYNC_STAGES-1];
    end
  end

  assign tms_o      = tms_q[SYNC_STAGES-1];
  assign tdi_o      = tdi_q[SYNC_STAGES-1];
  assign tck_rise_o = tck_q[SYNC_STAGES-1] & ~tck_prev_q;
  assign tck_fall_o = ~tck_q[SYNC_STAGES-1] & tck_prev_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP: oversampled 1149.1 controller with an instruction
// register, a BYPASS bit and a FIFO-backed data register (MSB first).
module jtag_tap_responder
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH    = 6,
  parameter int                  DR_WIDTH    = 8,
  parameter logic [IR_WIDTH-1:0] IR_DATA     = 6'h02,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output tap_state_t          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic                ir_update,
  input  logic [DR_WIDTH-1:0] tx_rdata,
  input  logic                tx_empty,
  output logic                tx_rd,
  output logic [DR_WIDTH-1:0] rx_wdata,
  output logic                rx_wr,
  input  logic                rx_full,
  output logic                rx_overflow
);

  localparam int                  CNT_W    = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DR_WIDTH - 1);
  localparam logic [IR_WIDTH-1:0] IR_ONES  = BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAP   = {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE};

  logic tms_sync;
  logic tdi_sync;
  logic tck_rise;
  logic tck_fall;

  tap_state_t          state_q,     state_d;
  logic [IR_WIDTH-1:0] ir_sr_q,     ir_sr_d;
  logic [IR_WIDTH-1:0] ir_value_q,  ir_value_d;
  logic [DR_WIDTH-1:0] dr_sr_q,     dr_sr_d;
  logic                bypass_q,    bypass_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                tdo_q,       tdo_d;
  logic [DR_WIDTH-1:0] rx_wdata_q,  rx_wdata_d;
  logic                rx_ovf_q,    rx_ovf_d;
  logic                ir_update_q, ir_update_d;
  logic                tx_rd_q,     tx_rd_d;
  logic                rx_wr_q,     rx_wr_d;

  logic                data_sel;
  logic                word_done;
  logic [DR_WIDTH-1:0] dr_shift;
  logic [DR_WIDTH-1:0] tx_word;

  jtag_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .tck_i      (tck),
    .tms_i      (tms),
    .tdi_i      (tdi),
    .tms_o      (tms_sync),
    .tdi_o      (tdi_sync),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall)
  );

  assign data_sel  = (ir_value_q == IR_DATA);
  assign word_done = (cnt_q == CNT_LAST);
  assign dr_shift  = {dr_sr_q[DR_WIDTH-2:0], tdi_sync};
  // An empty transmit FIFO shifts out zeros.
  assign tx_word   = tx_empty ? {DR_WIDTH{1'b0}} : tx_rdata;

  // Next-state: TAP transition and register actions on tck edges, plus the
  // per-clk housekeeping while parked in Test-Logic-Reset.
  always_comb begin
    state_d     = state_q;
    ir_sr_d     = ir_sr_q;
    ir_value_d  = ir_value_q;
    dr_sr_d     = dr_sr_q;
    bypass_d    = bypass_q;
    cnt_d       = cnt_q;
    tdo_d       = tdo_q;
    rx_wdata_d  = rx_wdata_q;
    rx_ovf_d    = rx_ovf_q;
    ir_update_d = 1'b0;
    tx_rd_d     = 1'b0;
    rx_wr_d     = 1'b0;

    if (tck_rise) begin
      state_d = tap_next(state_q, tms_sync);
      // Actions are keyed on the state being left, so the edge that exits
      // a Shift state still shifts.
      case (state_q)
        CAP_IR:   ir_sr_d = IR_CAP;
        SHIFT_IR: ir_sr_d = {ir_sr_q[IR_WIDTH-2:0], tdi_sync};
        UPD_IR: begin
          ir_value_d  = ir_sr_q;
          ir_update_d = 1'b1;
        end
        CAP_DR: begin
          bypass_d = 1'b0;
          if (data_sel) begin
            dr_sr_d = tx_word;
            tx_rd_d = ~tx_empty;
            cnt_d   = '0;
          end else begin
            dr_sr_d = dr_sr_q;
          end
        end
        SHIFT_DR: begin
          bypass_d = tdi_sync;
          if (data_sel && word_done) begin
            // Full word: hand it to the rx FIFO and reload from tx.
            rx_wdata_d = dr_shift;
            rx_wr_d    = ~rx_full;
            rx_ovf_d   = rx_ovf_q | rx_full;
            dr_sr_d    = tx_word;
            tx_rd_d    = ~tx_empty;
            cnt_d      = '0;
          end else if (data_sel) begin
            dr_sr_d = dr_shift;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            dr_sr_d = dr_sr_q;
          end
        end
        default:  ir_sr_d = ir_sr_q;
      endcase
    end else if (tck_fall) begin
      case (state_q)
        SHIFT_IR: tdo_d = ir_sr_q[IR_WIDTH-1];
        SHIFT_DR: tdo_d = data_sel ? dr_sr_q[DR_WIDTH-1] : bypass_q;
        default:  tdo_d = 1'b0;
      endcase
    end else begin
      tdo_d = tdo_q;
    end

    // TLR continuously forces BYPASS and clears the word state and sticky flag.
    if (state_q == TLR) begin
      ir_value_d = IR_ONES;
      cnt_d      = '0;
      rx_ovf_d   = 1'b0;
    end else begin
      rx_ovf_d   = rx_ovf_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TLR;
      ir_sr_q     <= '0;
      ir_value_q  <= IR_ONES;
      dr_sr_q     <= '0;
      bypass_q    <= 1'b0;
      cnt_q       <= '0;
      tdo_q       <= 1'b0;
      rx_wdata_q  <= '0;
      rx_ovf_q    <= 1'b0;
      ir_update_q <= 1'b0;
      tx_rd_q     <= 1'b0;
      rx_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_value_q  <= ir_value_d;
      dr_sr_q     <= dr_sr_d;
      bypass_q    <= bypass_d;
      cnt_q       <= cnt_d;
      tdo_q       <= tdo_d;
      rx_wdata_q  <= rx_wdata_d;
      rx_ovf_q    <= rx_ovf_d;
      ir_update_q <= ir_update_d;
      tx_rd_q     <= tx_rd_d;
      rx_wr_q     <= rx_wr_d;
    end
  end

  assign tdo         = tdo_q;
  assign tap_state   = state_q;
  assign ir_value    = ir_value_q;
  assign ir_update   = ir_update_q;
  assign tx_rd       = tx_rd_q;
  assign rx_wdata    = rx_wdata_q;
  assign rx_wr       = rx_wr_q;
  assign rx_overflow = rx_ovf_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: a JTAG master driver with a
// transaction-level reference model, and a monitor that checks FIFO/IR pulses.
module tb_jtag_tap_responder;
  import jtag_pkg::*;

  localparam logic [5:0] IR_DATA_OP = 6'h02;
  localparam int         HALF       = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tck = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       tdo;
  tap_state_t tap_state;
  logic [5:0] ir_value;
  logic       ir_update;
  logic [7:0] tx_rdata = 8'h00;
  logic       tx_empty = 1'b1;
  logic       tx_rd;
  logic [7:0] rx_wdata;
  logic       rx_wr;
  logic       rx_full = 1'b0;
  logic       rx_overflow;

  int checks = 0;
  int errors = 0;
  int tx_pops = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_exp[$];
  logic [5:0] ir_exp[$];

  // Reference TAP graph: {next on tms=0, next on tms=1}, standard 1149.1.
  int nxt [16][2] = '{'{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8},
                      '{6, 7}, '{4, 8}, '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12},
                      '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}};
  int         model_state = 0;
  logic [5:0] model_ir    = 6'h3F;

  jtag_tap_responder dut (
    .clk         (clk),
    .rst         (rst),
    .tck         (tck),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tap_state   (tap_state),
    .ir_value    (ir_value),
    .ir_update   (ir_update),
    .tx_rdata    (tx_rdata),
    .tx_empty    (tx_empty),
    .tx_rd       (tx_rd),
    .rx_wdata    (rx_wdata),
    .rx_wr       (rx_wr),
    .rx_full     (rx_full),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: consumes pulses, compares against queued expectations, models the tx FIFO.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_wr) begin
        if (rx_exp.size() == 0) check("rx_wr unexpected", 64'd1, 64'd0);
        else check("rx_wdata", 64'(rx_wdata), 64'(rx_exp.pop_front()));
      end
      if (ir_update) begin
        if (ir_exp.size() == 0) check("ir_update unexpected", 64'd1, 64'd0);
        else check("ir_value at update", 64'(ir_value), 64'(ir_exp.pop_front()));
      end
      if (tx_rd) begin
        tx_pops++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
    end
    tx_empty = (tx_q.size() == 0);
    tx_rdata = (tx_q.size() == 0) ? 8'h00 : tx_q[0];
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full tck period; tdo is sampled just before the rise, as a master would.
  task automatic tck_cycle(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    wait_clk(HALF);
    o   = tdo;
    tck = 1'b1;
    model_state = nxt[model_state][int'(m)];
    wait_clk(HALF);
    tck = 1'b0;
  endtask

  task automatic goto_tlr();
    logic b;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
    model_ir = 6'h3F;
    wait_clk(2);
    check("tlr state", 64'(tap_state), 64'(model_state));
  endtask

  task automatic load_ir(input logic [5:0] v);
    logic       b;
    logic [5:0] got;
    got = 6'h00;
    ir_exp.push_back(v);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 6; i++) begin
      tck_cycle(i == 5, v[5-i], b);
      got = {got[4:0], b};
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    model_ir = v;
    check("ir capture tdo", 64'(got), 64'(6'b000001));
    check("ir_value", 64'(ir_value), 64'(v));
    check("state after ir", 64'(tap_state), 64'(model_state));
  endtask

  // DR scan of n bits (first bit = data[n-1]); expectations from word-level model.
  task automatic dr_scan(input logic [63:0] data, input int n, input string tag);
    logic [63:0] got, expv;
    logic [7:0]  w;
    logic        b, dsel;
    int          s, pops0, loads, exp_pops;
    dsel  = (model_ir == IR_DATA_OP);
    s     = tx_q.size();
    pops0 = tx_pops;
    loads = 1 + n / 8;
    got   = 64'd0;
    expv  = 64'd0;
    for (int i = 0; i < n; i++) begin
      if (dsel) begin
        w = (i / 8 < s) ? tx_q[i/8] : 8'h00;
        b = w[7 - (i % 8)];
      end else begin
        b = (i == 0) ? 1'b0 : data[n-i];
      end
      expv = {expv[62:0], b};
    end
    if (dsel && !rx_full) begin
      for (int k = 0; k < n / 8; k++) rx_exp.push_back(data[n-1-8*k -: 8]);
    end
    exp_pops = dsel ? ((loads < s) ? loads : s) : 0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, data[n-1-i], b);
      got = {got[62:0], b};
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check({tag, " tdo"}, got, expv);
    check({tag, " tx pops"}, 64'(tx_pops - pops0), 64'(exp_pops));
    check({tag, " state"}, 64'(tap_state), 64'(model_state));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       b;
    logic [5:0] op;
    int         n, cnt;

    // Reset values.
    wait_clk(3);
    check("reset tap_state", 64'(tap_state), 64'(TLR));
    check("reset ir_value", 64'(ir_value), 64'(BYPASS[5:0]));
    check("reset tdo", 64'(tdo), 64'd0);
    check("reset pulses", 64'({ir_update, tx_rd, rx_wr}), 64'd0);
    check("reset overflow", 64'(rx_overflow), 64'd0);
    check("reset rx_wdata", 64'(rx_wdata), 64'd0);
    rst = 1'b0;
    wait_clk(2);

    // From SHIFT_DR, five tms=1 rises return to TLR.
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("reach shift_dr", 64'(tap_state), 64'(SHIFT_DR));
    goto_tlr();

    // IR load then the directed DATA stream.
    load_ir(IR_DATA_OP);
    tx_q = '{8'h81, 8'h3C, 8'h00, 8'hFF};
    wait_clk(2);
    dr_scan(64'hA55A_1234, 32, "stream");

    // Randomized DATA scans, including partial trailing words.
    for (int it = 0; it < 6; it++) begin
      tx_q.delete();
      cnt = $urandom_range(0, 4);
      for (int k = 0; k < cnt; k++) tx_q.push_back(8'($urandom));
      wait_clk(2);
      n = $urandom_range(1, 30);
      dr_scan({$urandom, $urandom}, n, "rand data");
    end

    // Empty tx FIFO: zeros out, no pops.
    tx_q.delete();
    wait_clk(2);
    dr_scan(64'h0000_C3A7, 16, "tx empty");

    // Twelve bits: one word pushed, partial dropped.
    tx_q = '{8'h5E};
    wait_clk(2);
    dr_scan(64'h0000_0ABC, 12, "partial");

    // Full rx FIFO: no push, sticky overflow until TLR.
    rx_full = 1'b1;
    dr_scan(64'h0000_0077, 8, "rx full");
    rx_full = 1'b0;
    wait_clk(2);
    check("overflow set", 64'(rx_overflow), 64'd1);
    dr_scan(64'h0000_0001, 3, "overflow hold");
    check("overflow sticky", 64'(rx_overflow), 64'd1);
    goto_tlr();
    check("overflow cleared", 64'(rx_overflow), 64'd0);
    check("tlr ir bypass", 64'(ir_value), 64'(6'h3F));

    // BYPASS: one-tck delay.
    load_ir(6'h3F);
    dr_scan(64'hB, 4, "bypass 1011");
    for (int it = 0; it < 3; it++) begin
      op = 6'($urandom_range(3, 62));
      load_ir(op);
      dr_scan({$urandom, $urandom}, $urandom_range(1, 20), "rand bypass");
    end

    // Reset in the middle of a DATA word.
    load_ir(IR_DATA_OP);
    tx_q.delete();
    wait_clk(2);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'($urandom), b);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    model_state = 0;
    model_ir    = 6'h3F;
    wait_clk(2);
    check("midrst state", 64'(tap_state), 64'(TLR));
    check("midrst ir_value", 64'(ir_value), 64'(6'h3F));
    check("midrst tdo", 64'(tdo), 64'd0);
    check("midrst rx_wdata", 64'(rx_wdata), 64'd0);
    load_ir(IR_DATA_OP);
    tx_q = '{8'h96};
    wait_clk(2);
    dr_scan(64'h0000_00E1, 8, "post reset");

    wait_clk(4);
    check("rx expectations drained", 64'(rx_exp.size()), 64'd0);
    check("ir expectations drained", 64'(ir_exp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
